// File: rtl/pps_sync_ctrl.sv
// -----------------------------------------------------------------------------
// pps_sync_ctrl
//
// Qualifies an external 1 PPS input against a nominal period, locks after a
// run of good periods, forwards good edges as a fixed-width sync strobe, and
// free-runs internal syncs (holdover) for a bounded number of periods when
// the reference disappears. Also holds the active pulse-generator
// configuration, which only changes on the rising edge of o_sync.
//
// Ports
//   i_clk              single clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   SYNC               external PPS, asynchronous to i_clk
//   i_cfg_valid        configuration request strobe
//   i_cfg_pulse_num    requested pulse count (must be nonzero)
//   i_cfg_half_period  requested half period (must be nonzero)
//   o_cfg_ready        request can be accepted this cycle
//   o_cfg_err          one-cycle flag: request rejected (zero value)
//   o_sync             sync strobe, SYNC_WIDTH cycles high
//   o_pulse_num        active pulse count
//   o_half_period      active half period
//   o_locked           state is LOCKED
//   o_holdover         state is HOLDOVER
//   o_state            0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER
//   o_period           counter value captured on the last detected edge
// -----------------------------------------------------------------------------
module pps_sync_ctrl #(
  parameter int unsigned NOMINAL     = 100000000,
  parameter int unsigned TOL         = 1000000,
  parameter int unsigned LOCK_CNT    = 2,
  parameter int unsigned HOLD_MAX    = 10,
  parameter int unsigned SYNC_WIDTH  = 8,
  parameter int unsigned PULSE_NUM   = 100,
  parameter int unsigned HALF_PERIOD = 500000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        SYNC,
  input  logic        i_cfg_valid,
  input  logic [31:0] i_cfg_pulse_num,
  input  logic [31:0] i_cfg_half_period,
  output logic        o_cfg_ready,
  output logic        o_cfg_err,
  output logic        o_sync,
  output logic [31:0] o_pulse_num,
  output logic [31:0] o_half_period,
  output logic        o_locked,
  output logic        o_holdover,
  output logic [2:0]  o_state,
  output logic [31:0] o_period
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_LOCKED   = 3'd2,
    ST_HOLDOVER = 3'd3
  } state_t;

  localparam logic [31:0] WIN_LO  = 32'(NOMINAL - TOL);
  localparam logic [31:0] WIN_HI  = 32'(NOMINAL + TOL);
  localparam logic [31:0] NOM     = 32'(NOMINAL);
  localparam logic [15:0] LOCK_N  = 16'(LOCK_CNT);
  localparam logic [15:0] HOLD_N  = 16'(HOLD_MAX);
  localparam logic [15:0] WIDTH_N = 16'(SYNC_WIDTH);

  state_t      state;
  logic        sync_meta;
  logic        sync_stab;
  logic        sync_prev;
  logic [31:0] cnt;
  logic [15:0] good_cnt;
  logic [15:0] hold_cnt;
  logic [15:0] sync_left;
  logic        pending;
  logic [31:0] stg_pulse_num;
  logic [31:0] stg_half_period;

  logic        edge_det;
  logic        in_win;
  logic        good_edge;
  logic        sync_req;
  logic        cfg_ok;

  always_comb begin
    edge_det  = sync_stab & ~sync_prev;
    in_win    = (cnt >= WIN_LO) && (cnt <= WIN_HI);
    good_edge = edge_det & in_win;
    cfg_ok    = (i_cfg_pulse_num != 32'd0) && (i_cfg_half_period != 32'd0);
    sync_req  = 1'b0;
    case (state)
      // A good edge is forwarded; at the top of the window with no edge the
      // timeout itself produces the first holdover sync.
      ST_LOCKED:   sync_req = good_edge || (cnt >= WIN_HI);
      // A detected edge takes priority over an internal sync; the sync that
      // would exceed the holdover budget is never issued.
      ST_HOLDOVER: sync_req = !edge_det && (cnt >= NOM) && (hold_cnt < HOLD_N);
      default:     sync_req = 1'b0;
    endcase
  end

  assign o_cfg_ready = !o_sync && !pending;
  assign o_state     = state;
  assign o_locked    = (state == ST_LOCKED);
  assign o_holdover  = (state == ST_HOLDOVER);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      sync_meta       <= 1'b0;
      sync_stab       <= 1'b0;
      sync_prev       <= 1'b0;
      cnt             <= 32'd0;
      good_cnt        <= 16'd0;
      hold_cnt        <= 16'd0;
      sync_left       <= 16'd0;
      pending         <= 1'b0;
      stg_pulse_num   <= 32'd0;
      stg_half_period <= 32'd0;
      o_sync          <= 1'b0;
      o_cfg_err       <= 1'b0;
      o_period        <= 32'd0;
      o_pulse_num     <= 32'(PULSE_NUM);
      o_half_period   <= 32'(HALF_PERIOD);
    end else begin
      sync_meta <= SYNC;
      sync_stab <= sync_meta;
      sync_prev <= sync_stab;
      o_cfg_err <= 1'b0;

      // Saturating count; any restart below overrides the increment.
      if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
      if (edge_det) o_period <= cnt;

      case (state)
        ST_IDLE: begin
          if (edge_det) begin
            state    <= ST_ACQUIRE;
            good_cnt <= 16'd0;
            cnt      <= 32'd1;
          end
        end
        ST_ACQUIRE: begin
          if (edge_det) begin
            cnt <= 32'd1;
            if (in_win) begin
              good_cnt <= good_cnt + 16'd1;
              if (good_cnt + 16'd1 == LOCK_N) state <= ST_LOCKED;
            end else begin
              good_cnt <= 16'd0;
            end
          end else if (cnt > WIN_HI) begin
            good_cnt <= 16'd0;
            cnt      <= 32'd1;
          end
        end
        ST_LOCKED: begin
          // Early edges are ignored entirely: the period keeps running.
          if (good_edge) begin
            cnt <= 32'd1;
          end else if (cnt >= WIN_HI) begin
            state    <= ST_HOLDOVER;
            hold_cnt <= 16'd1;
            cnt      <= 32'd1;
          end
        end
        ST_HOLDOVER: begin
          if (edge_det) begin
            state    <= ST_ACQUIRE;
            good_cnt <= 16'd0;
            cnt      <= 32'd1;
          end else if (cnt >= NOM) begin
            if (hold_cnt >= HOLD_N) begin
              state    <= ST_IDLE;
              hold_cnt <= 16'd0;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
              cnt      <= 32'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Strobe generator; requests arriving while the strobe is high are lost.
      if (o_sync) begin
        if (sync_left == 16'd1) o_sync <= 1'b0;
        sync_left <= sync_left - 16'd1;
      end else if (sync_req) begin
        o_sync    <= 1'b1;
        sync_left <= WIDTH_N;
        if (pending) begin
          o_pulse_num   <= stg_pulse_num;
          o_half_period <= stg_half_period;
          pending       <= 1'b0;
        end
      end

      // Accept only when ready, which excludes the copy above in this cycle.
      if (i_cfg_valid && o_cfg_ready) begin
        if (cfg_ok) begin
          stg_pulse_num   <= i_cfg_pulse_num;
          stg_half_period <= i_cfg_half_period;
          pending         <= 1'b1;
        end else begin
          o_cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pps_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pps_sync_ctrl
//
// Drives PPS edges with chosen and random spacing plus configuration requests
// into pps_sync_ctrl. A timestamp-based reference model predicts the state,
// strobe windows and configuration; predicted strobe rises go into a queue
// that a negedge monitor drains whenever the DUT raises o_sync.
// -----------------------------------------------------------------------------
module tb_pps_sync_ctrl;

  localparam int NOMINAL     = 100;
  localparam int TOL         = 5;
  localparam int LOCK_CNT    = 2;
  localparam int HOLD_MAX    = 3;
  localparam int SYNC_WIDTH  = 8;
  localparam int PULSE_NUM   = 100;
  localparam int HALF_PERIOD = 500000;

  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync_in = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_pn = 32'd0;
  logic [31:0] cfg_hp = 32'd0;
  logic        o_cfg_ready, o_cfg_err, o_sync, o_locked, o_holdover;
  logic [31:0] o_pulse_num, o_half_period, o_period;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  pps_sync_ctrl #(
    .NOMINAL(NOMINAL), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .HOLD_MAX(HOLD_MAX),
    .SYNC_WIDTH(SYNC_WIDTH), .PULSE_NUM(PULSE_NUM), .HALF_PERIOD(HALF_PERIOD)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .SYNC(sync_in),
    .i_cfg_valid(cfg_valid), .i_cfg_pulse_num(cfg_pn), .i_cfg_half_period(cfg_hp),
    .o_cfg_ready(o_cfg_ready), .o_cfg_err(o_cfg_err), .o_sync(o_sync),
    .o_pulse_num(o_pulse_num), .o_half_period(o_half_period),
    .o_locked(o_locked), .o_holdover(o_holdover), .o_state(o_state),
    .o_period(o_period)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          at;
    logic [31:0] pn;
    logic [31:0] hp;
  } rise_t;

  int    edge_q[$];     // clock index at which each driven edge is acted on
  rise_t rise_q[$];     // predicted strobe rises

  int          m_mode = M_IDLE;
  int          m_good = 0;
  int          m_hold = 0;
  int          m_ref = 0;          // clock index of the last reference point
  int          m_ss = -1000;       // clock index at which the last strobe rose
  bit          m_fresh = 1'b1;
  bit          m_pend = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_period = 32'd0;
  logic [31:0] m_pn = 32'(PULSE_NUM);
  logic [31:0] m_hp = 32'(HALF_PERIOD);
  logic [31:0] m_spn = 32'd0;
  logic [31:0] m_shp = 32'd0;

  // Strobe high after clock index k?
  function automatic bit strobe_on(input int k);
    return (k >= m_ss) && (k <= m_ss + SYNC_WIDTH - 1);
  endfunction

  always @(posedge clk) begin : model
    int n;
    int since;
    bit ev;
    bit in_win;
    bit want;
    bit ready_pre;
    cyc = cyc + 1;
    n = cyc;
    if (!rst_n) begin
      m_mode = M_IDLE; m_good = 0; m_hold = 0; m_ss = -1000; m_fresh = 1'b1;
      m_pend = 1'b0; m_err = 1'b0; m_period = 32'd0;
      m_pn = 32'(PULSE_NUM); m_hp = 32'(HALF_PERIOD);
    end else begin
      // The period count reads 0 on the first clock after reset.
      if (m_fresh) begin m_ref = n; m_fresh = 1'b0; end
      ev = 1'b0;
      while (edge_q.size() > 0 && edge_q[0] < n) void'(edge_q.pop_front());
      if (edge_q.size() > 0 && edge_q[0] == n) begin ev = 1'b1; void'(edge_q.pop_front()); end
      since  = n - m_ref;
      in_win = (since >= NOMINAL - TOL) && (since <= NOMINAL + TOL);
      want   = 1'b0;
      if (ev) m_period = 32'(since);
      if (m_mode == M_IDLE) begin
        if (ev) begin m_mode = M_ACQ; m_good = 0; m_ref = n; end
      end else if (m_mode == M_ACQ) begin
        if (ev && in_win) begin
          m_ref = n; m_good++;
          if (m_good == LOCK_CNT) m_mode = M_LOCK;
        end else if (ev || since > NOMINAL + TOL) begin
          m_ref = n; m_good = 0;
        end
      end else if (m_mode == M_LOCK) begin
        if (ev && in_win) begin want = 1'b1; m_ref = n; end
        else if (since >= NOMINAL + TOL) begin
          m_mode = M_HOLD; m_hold = 1; want = 1'b1; m_ref = n;
        end
      end else begin
        if (ev) begin m_mode = M_ACQ; m_good = 0; m_ref = n; end
        else if (since >= NOMINAL) begin
          if (m_hold + 1 > HOLD_MAX) m_mode = M_IDLE;
          else begin m_hold++; want = 1'b1; m_ref = n; end
        end
      end
      ready_pre = !strobe_on(n - 1) && !m_pend;
      if (want && !strobe_on(n - 1)) begin
        m_ss = n;
        if (m_pend) begin m_pn = m_spn; m_hp = m_shp; m_pend = 1'b0; end
        rise_q.push_back('{n, m_pn, m_hp});
      end
      m_err = 1'b0;
      if (cfg_valid && ready_pre) begin
        if (cfg_pn != 0 && cfg_hp != 0) begin m_spn = cfg_pn; m_shp = cfg_hp; m_pend = 1'b1; end
        else m_err = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  bit mon_prev = 1'b0;
  int mon_len = 0;

  always @(negedge clk) begin : monitor
    rise_t r;
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_len = 0;
    end else begin
      chk("state", o_state, m_mode);
      chk("locked", o_locked, m_mode == M_LOCK);
      chk("holdover", o_holdover, m_mode == M_HOLD);
      chk("sync_level", o_sync, strobe_on(cyc));
      chk("cfg_ready", o_cfg_ready, !strobe_on(cyc) && !m_pend);
      chk("cfg_err", o_cfg_err, m_err);
      chk("period", o_period, m_period);
      chk("pulse_num", o_pulse_num, m_pn);
      chk("half_period", o_half_period, m_hp);
      if (o_sync && !mon_prev) begin
        chk("rise_expected", rise_q.size() != 0, 1);
        if (rise_q.size() != 0) begin
          r = rise_q.pop_front();
          chk("rise_cycle", cyc, r.at);
          chk("rise_pulse_num", o_pulse_num, r.pn);
          chk("rise_half_period", o_half_period, r.hp);
        end
        $display("sync rise: cycle %0d state %0d pulse_num %0d half_period %0d",
                 cyc, o_state, o_pulse_num, o_half_period);
      end
      if (o_sync) mon_len++;
      if (!o_sync && mon_prev) begin
        chk("sync_width", mon_len, SYNC_WIDTH);
        mon_len = 0;
      end
      mon_prev = o_sync;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_cfg = 1'b0;
  int drive_c = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    if (rand_cfg && $urandom_range(0, 39) == 0) begin
      cfg_valid = 1'b1;
      cfg_pn = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      cfg_hp = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000000));
      $display("cfg request: cycle %0d pulse_num %0d half_period %0d ready %0d",
               cyc, cfg_pn, cfg_hp, o_cfg_ready);
    end
  endtask

  // Raise SYNC so that its edge is acted on `gap` clocks after the previous one.
  task automatic edge_at(input int gap);
    while (cyc < drive_c + gap) step();
    sync_in = 1'b1;
    drive_c = cyc;
    edge_q.push_back(cyc + 3);
    $display("pps edge: driven at cycle %0d, gap %0d", cyc, gap);
    repeat (3) step();
    sync_in = 1'b0;
  endtask

  task automatic cfg_req(input logic [31:0] pn, input logic [31:0] hp);
    cfg_valid = 1'b1;
    cfg_pn = pn;
    cfg_hp = hp;
    $display("cfg request: cycle %0d pulse_num %0d half_period %0d ready %0d",
             cyc, pn, hp, o_cfg_ready);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sync"}, o_sync, 0);
    chk({tag, "_state"}, o_state, M_IDLE);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_holdover"}, o_holdover, 0);
    chk({tag, "_period"}, o_period, 0);
    chk({tag, "_cfg_err"}, o_cfg_err, 0);
    chk({tag, "_cfg_ready"}, o_cfg_ready, 1);
    chk({tag, "_pulse_num"}, o_pulse_num, PULSE_NUM);
    chk({tag, "_half_period"}, o_half_period, HALF_PERIOD);
  endtask

  task automatic apply_reset();
    rand_cfg = 1'b0;
    rst_n = 1'b0;
    sync_in = 1'b0;
    cfg_valid = 1'b0;
    edge_q.delete();
    #1;
    check_reset_values("reset");
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int r;
    int gap;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    repeat (2) step();
    rst_n = 1'b1;

    // Regular edges: acquire, lock after the third, strobes from the fourth.
    drive_c = cyc;
    edge_at(0);
    repeat (5) edge_at(100);

    // Early edge while locked is ignored; the next on-time edge is forwarded.
    edge_at(50);
    edge_at(50);

    // Good configuration is staged and applied on the next strobe rise.
    repeat (12) step();
    cfg_req(32'd50, 32'd250000);
    edge_at(100 - (cyc - drive_c) + (cyc - drive_c));
    // Zero value is rejected with a one-cycle error pulse.
    repeat (12) step();
    cfg_req(32'd0, 32'd250000);
    edge_at(100);

    // Reference lost: timeout sync, then internal syncs until the budget ends.
    repeat (500) step();

    // Relock, lose reference, then an edge 40 clocks after the first internal sync.
    drive_c = cyc;
    edge_at(0);
    repeat (4) edge_at(100);
    edge_at(NOMINAL + TOL + 40);
    repeat (3) edge_at(100);

    // Reset three clocks into a strobe.
    edge_at(100);
    repeat (2) step();
    chk("sync_before_reset", o_sync, 1);
    apply_reset();

    // Randomized edges and configuration requests.
    rand_cfg = 1'b1;
    drive_c = cyc;
    edge_at(0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      gap = $urandom_range(NOMINAL - TOL, NOMINAL + TOL);
      else if (r < 80) gap = $urandom_range(10, NOMINAL - TOL - 1);
      else if (r < 90) gap = $urandom_range(NOMINAL + TOL + 1, 140);
      else             gap = $urandom_range(250, 480);
      edge_at(gap);
    end
    rand_cfg = 1'b0;
    repeat (600) step();

    chk("rise_queue_drained", rise_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
